// File: rtl/phase_speed_avg.sv
// Phase-to-speed averager: block or sliding mean of signed phase samples,
// rounded, scaled by an unsigned gain and saturated to the output width.
module phase_speed_avg #(
    parameter int unsigned LOG2_WIN    = 6,
    parameter int unsigned PHASE_W     = 19,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned SCALE_W     = 16,
    parameter int unsigned SCALE_SHIFT = 11
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      mode,
    input  logic                      sample,
    input  logic signed [PHASE_W-1:0] phase,
    input  logic        [SCALE_W-1:0] scale,
    output logic signed [OUT_W-1:0]   speed,
    output logic                      valid,
    output logic                      sat,
    output logic                      filled
);

    localparam int unsigned WIN    = 1 << LOG2_WIN;
    localparam int unsigned SUM_W  = PHASE_W + LOG2_WIN;
    localparam int unsigned PROD_W = PHASE_W + SCALE_W + 1;

    localparam logic signed [SUM_W:0]  AVG_HALF = (SUM_W+1)'(1) << (LOG2_WIN - 1);
    localparam logic signed [PROD_W:0] RND_HALF = (PROD_W+1)'(1) << (SCALE_SHIFT - 1);
    localparam logic signed [PROD_W:0] OUT_MAX  =
        (PROD_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W:0] OUT_MIN  = -OUT_MAX - (PROD_W+1)'(1);

    logic                      mode_q,     mode_d;
    logic [LOG2_WIN-1:0]       count_q,    count_d;
    logic signed [SUM_W-1:0]   sum_q,      sum_d;
    logic                      filled_q,   filled_d;
    logic                      s1_valid_q, s1_valid_d;
    logic signed [SUM_W-1:0]   s1_sum_q,   s1_sum_d;
    logic                      s2_valid_q, s2_valid_d;
    logic signed [PHASE_W-1:0] avg_q,      avg_d;
    logic                      s3_valid_q, s3_valid_d;
    logic signed [PROD_W-1:0]  prod_q,     prod_d;
    logic                      valid_q,    valid_d;
    logic signed [OUT_W-1:0]   speed_q,    speed_d;
    logic                      sat_q,      sat_d;

    logic signed [PHASE_W-1:0] hist_mem [WIN];

    logic                      flush;
    logic                      accept;
    logic                      last;
    logic                      hist_we;
    logic signed [PHASE_W-1:0] evict;
    logic signed [SUM_W-1:0]   sum_in;
    logic signed [PROD_W:0]    rnd_wide;
    logic                      over_hi;
    logic                      over_lo;

    // Accumulate stage; count_q doubles as the history write pointer.
    always_comb begin
        mode_d     = mode;
        flush      = clear | (mode != mode_q);
        accept     = sample & ~flush;
        last       = (count_q == LOG2_WIN'(WIN - 1));
        hist_we    = accept & mode_q;
        evict      = filled_q ? hist_mem[count_q] : '0;
        sum_in     = SUM_W'(phase);
        sum_d      = sum_q;
        count_d    = count_q;
        filled_d   = filled_q;
        s1_valid_d = 1'b0;
        s1_sum_d   = s1_sum_q;
        if (flush) begin
            sum_d    = '0;
            count_d  = '0;
            filled_d = 1'b0;
        end else if (accept) begin
            count_d = count_q + 1'b1;
            if (mode_q) begin
                sum_d      = sum_q + sum_in - SUM_W'(evict);
                s1_sum_d   = sum_d;
                s1_valid_d = filled_q | last;
                filled_d   = filled_q | last;
            end else begin
                s1_sum_d   = sum_q + sum_in;
                s1_valid_d = last;
                sum_d      = last ? '0 : s1_sum_d;
            end
        end
    end

    // Average, scale and saturate stages.
    always_comb begin
        s2_valid_d = s1_valid_q & ~flush;
        avg_d      = avg_q;
        if (s1_valid_q) begin
            avg_d = PHASE_W'(($signed({s1_sum_q[SUM_W-1], s1_sum_q}) + AVG_HALF) >>> LOG2_WIN);
        end

        s3_valid_d = s2_valid_q & ~flush;
        prod_d     = prod_q;
        if (s2_valid_q) begin
            prod_d = PROD_W'(avg_q) * PROD_W'($signed({1'b0, scale}));
        end

        rnd_wide = ($signed({prod_q[PROD_W-1], prod_q}) + RND_HALF) >>> SCALE_SHIFT;
        over_hi  = (rnd_wide > OUT_MAX);
        over_lo  = (rnd_wide < OUT_MIN);
        valid_d  = s3_valid_q & ~flush;
        speed_d  = speed_q;
        sat_d    = flush ? 1'b0 : sat_q;
        if (valid_d) begin
            if (over_hi) begin
                speed_d = OUT_MAX[OUT_W-1:0];
            end else if (over_lo) begin
                speed_d = OUT_MIN[OUT_W-1:0];
            end else begin
                speed_d = rnd_wide[OUT_W-1:0];
            end
            if (over_hi | over_lo) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
            filled_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            avg_q      <= '0;
            s3_valid_q <= 1'b0;
            prod_q     <= '0;
            valid_q    <= 1'b0;
            speed_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            filled_q   <= filled_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            avg_q      <= avg_d;
            s3_valid_q <= s3_valid_d;
            prod_q     <= prod_d;
            valid_q    <= valid_d;
            speed_q    <= speed_d;
            sat_q      <= sat_d;
        end
    end

    // History is never reset; filled_q masks stale entries from the sum.
    always_ff @(posedge clock) begin
        if (hist_we) begin
            hist_mem[count_q] <= phase;
        end
    end

    assign speed  = speed_q;
    assign valid  = valid_q;
    assign sat    = sat_q;
    assign filled = filled_q;

endmodule

// File: tb/tb_phase_speed_avg.sv
// Directed bench for phase_speed_avg with LOG2_WIN=2, SCALE_SHIFT=4.
module tb_phase_speed_avg;

    localparam int unsigned LOG2_WIN    = 2;
    localparam int unsigned PHASE_W     = 19;
    localparam int unsigned OUT_W       = 16;
    localparam int unsigned SCALE_W     = 16;
    localparam int unsigned SCALE_SHIFT = 4;

    logic                      clock   = 1'b0;
    logic                      reset_n = 1'b1;
    logic                      clear   = 1'b0;
    logic                      mode    = 1'b0;
    logic                      sample  = 1'b0;
    logic signed [PHASE_W-1:0] phase   = '0;
    logic        [SCALE_W-1:0] scale   = 16'd16;
    logic signed [OUT_W-1:0]   speed;
    logic                      valid;
    logic                      sat;
    logic                      filled;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    phase_speed_avg #(
        .LOG2_WIN   (LOG2_WIN),
        .PHASE_W    (PHASE_W),
        .OUT_W      (OUT_W),
        .SCALE_W    (SCALE_W),
        .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (clear),
        .mode   (mode),
        .sample (sample),
        .phase  (phase),
        .scale  (scale),
        .speed  (speed),
        .valid  (valid),
        .sat    (sat),
        .filled (filled)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Four back-to-back samples; valid must appear exactly on the third edge after the last.
    task automatic run_block(input string tag, input int p0, input int p1,
                             input int p2, input int p3, input int exp);
        int ps[4];
        ps = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            sample = 1'b1;
            phase  = PHASE_W'(ps[i]);
            cyc();
            chk({tag, "_early"}, 32'(valid), 0);
        end
        sample = 1'b0;
        cyc();
        chk({tag, "_lat1"}, 32'(valid), 0);
        cyc();
        chk({tag, "_lat2"}, 32'(valid), 0);
        cyc();
        chk({tag, "_valid"}, 32'(valid), 1);
        chk({tag, "_speed"}, 32'(speed), 32'(exp));
        cyc();
        chk({tag, "_pulse"}, 32'(valid), 0);
    endtask

    task automatic push4(input int p);
        for (int i = 0; i < 4; i++) begin
            sample = 1'b1;
            phase  = PHASE_W'(p);
            cyc();
        end
        sample = 1'b0;
    endtask

    initial begin
        int sl_in[6];
        int sl_exp[3];
        sl_in  = '{4, 8, 12, 16, 20, 24};
        sl_exp = '{10, 14, 18};

        #1 reset_n = 1'b0;
        #2;
        chk("rst_speed", 32'(speed), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_filled", 32'(filled), 0);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        run_block("blk100a", 100, 100, 100, 100, 100);
        run_block("blk100b", 100, 100, 100, 100, 100);
        chk("blk_filled", 32'(filled), 0);

        run_block("rnd_pos", 1, 1, 1, 0, 1);
        run_block("rnd_neg", -1, -1, -1, 0, -1);
        run_block("rnd_half", 1, 1, 0, 0, 1);

        // Gain change before the scale edge takes effect.
        push4(20);
        cyc();
        scale = 16'd32;
        cyc();
        cyc();
        chk("scl_early_valid", 32'(valid), 1);
        chk("scl_early_speed", 32'(speed), 40);
        scale = 16'd16;
        cyc();
        // Gain change after the scale edge does not.
        push4(20);
        cyc();
        cyc();
        scale = 16'd32;
        cyc();
        chk("scl_late_valid", 32'(valid), 1);
        chk("scl_late_speed", 32'(speed), 20);
        cyc();

        chk("sat_before", 32'(sat), 0);
        run_block("sat_pos", 40000, 40000, 40000, 40000, 32767);
        chk("sat_set", 32'(sat), 1);
        run_block("sat_neg", -40000, -40000, -40000, -40000, -32768);
        chk("sat_sticky", 32'(sat), 1);
        scale = 16'd16;
        run_block("sat_norm", 5, 5, 5, 5, 5);
        chk("sat_still", 32'(sat), 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("sat_cleared", 32'(sat), 0);
        chk("clr_hold_speed", 32'(speed), 5);

        mode = 1'b1;
        cyc();
        for (int t = 0; t < 9; t++) begin
            if (t < 6) begin
                sample = 1'b1;
                phase  = PHASE_W'(sl_in[t]);
            end else begin
                sample = 1'b0;
            end
            cyc();
            chk("slide_valid", 32'(valid), (t >= 6) ? 32'd1 : 32'd0);
            chk("slide_filled", 32'(filled), (t >= 3) ? 32'd1 : 32'd0);
            if (t >= 6) begin
                chk("slide_speed", 32'(speed), 32'(sl_exp[t-6]));
            end
        end

        mode = 1'b0;
        cyc();
        chk("mode_filled", 32'(filled), 0);
        chk("mode_hold_speed", 32'(speed), 18);

        for (int i = 0; i < 2; i++) begin
            sample = 1'b1;
            phase  = PHASE_W'(7);
            cyc();
        end
        clear  = 1'b1;
        phase  = PHASE_W'(999);
        cyc();
        clear  = 1'b0;
        sample = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("clr_noval", 32'(valid), 0);
        end
        run_block("clr_after", 50, 50, 50, 50, 50);

        push4(60);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("inflight_noval", 32'(valid), 0);
        end
        chk("inflight_speed", 32'(speed), 50);

        push4(70);
        for (int i = 0; i < 2; i++) begin
            sample = 1'b1;
            phase  = PHASE_W'(70);
            cyc();
        end
        sample = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_speed", 32'(speed), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_sat", 32'(sat), 0);
        chk("arst_filled", 32'(filled), 0);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("arst_noval", 32'(valid), 0);
        end
        run_block("arst_after", 30, 30, 30, 30, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
